// File: rtl/step_controller.sv
// ----------------------------------------------------------------------------
// step_controller
//
// Clock/reset front end for the single-cycle RISC-V core on the DE1-SoC.
// Runs on the 50 MHz board clock, synchronizes and debounces the raw step and
// reset keys, and turns each accepted key press (manual mode) or each run
// divider tick (auto-run mode) into one fixed-width processor clock pulse.
// Also counts issued steps for the debug display.
//
// Ports
//   clk         in   50 MHz board clock
//   reset       in   asynchronous active-low reset of this block
//   key_step_n  in   raw step key, active-low, asynchronous to clk
//   key_rst_n   in   raw processor-reset key, active-low, asynchronous
//   run_mode    in   0 = manual step, 1 = auto-run (synchronized internally)
//   cpu_clk     out  processor clock, registered
//   step_pulse  out  one-clk strobe coincident with each cpu_clk rising edge
//   cpu_reset   out  debounced processor reset, active-high, registered
//   step_count  out  steps issued since the last cpu_reset (wraps at 16 bits)
// ----------------------------------------------------------------------------
module step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_HIGH      = 4,
    parameter int RUN_DIV         = 12500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_step_n,
    input  logic        key_rst_n,
    input  logic        run_mode,
    output logic        cpu_clk,
    output logic        step_pulse,
    output logic        cpu_reset,
    output logic [15:0] step_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PH_W = (PULSE_HIGH > 1) ? $clog2(PULSE_HIGH) : 1;
    localparam int RD_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PULSE_HIGH - 1);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Bit order of the synchronizer vectors: [0] step key, [1] reset key,
    // [2] run_mode.
    logic [2:0] sync1;
    logic [2:0] sync2;

    logic       step_sync;
    logic       rst_sync;
    logic       run_sync;

    // Debounced key levels: [0] step key, [1] reset key (1 = released).
    logic [1:0]      deb;
    logic [DB_W-1:0] db_cnt [2];

    logic            deb_step_q;
    logic            step_fall;
    logic            step_rise;
    logic            rst_hold;
    logic            auto_tick;
    logic            trigger;

    logic            armed;
    logic [RD_W-1:0] run_div;
    logic [PH_W-1:0] ph_cnt;
    state_t          state;

    // ------------------------------------------------------------------
    // Two-flop synchronizers. Everything idles at 1 so that released keys
    // look released straight out of reset.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real flops do.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {run_mode, key_rst_n, key_step_n};
            sync2 <= sync1;
        end
    end

    assign step_sync = sync2[0];
    assign rst_sync  = sync2[1];
    assign run_sync  = sync2[2];

    // ------------------------------------------------------------------
    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive synced samples disagree with the current debounced level.
    // ------------------------------------------------------------------
    // NOTE: the counter array is tiny control state, so it is reset like
    // any other register; large storage arrays would normally be left
    // unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb <= '1;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign step_fall = deb_step_q & ~deb[0];
    assign step_rise = ~deb_step_q & deb[0];

    // The hold uses the debounced level directly so the FSM, divider and
    // count are cleared on the same edge that raises the registered
    // cpu_reset output.
    assign rst_hold  = ~deb[1];

    assign auto_tick = run_sync & (run_div == RD_LAST);
    assign trigger   = run_sync ? auto_tick : (step_fall & armed);

    // ------------------------------------------------------------------
    // Step FSM, run divider, step counter and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_reset  <= 1'b0;
            deb_step_q <= 1'b1;
            armed      <= 1'b1;
            run_div    <= '0;
            ph_cnt     <= '0;
            state      <= IDLE;
            cpu_clk    <= 1'b0;
            step_pulse <= 1'b0;
            step_count <= '0;
        end else begin
            cpu_reset  <= rst_hold;
            deb_step_q <= deb[0];
            step_pulse <= 1'b0;

            // One step per press: disarm on the debounced press, re-arm
            // only once the key is seen released again.
            if (step_fall) begin
                armed <= 1'b0;
            end else if (step_rise) begin
                armed <= 1'b1;
            end

            if (rst_hold) begin
                run_div    <= '0;
                ph_cnt     <= '0;
                state      <= IDLE;
                cpu_clk    <= 1'b0;
                step_count <= '0;
            end else begin
                // The divider free-runs through HIGH/LOW, so a tick that
                // lands mid-pulse is simply lost.
                if (!run_sync || run_div == RD_LAST) begin
                    run_div <= '0;
                end else begin
                    run_div <= run_div + 1'b1;
                end

                case (state)
                    IDLE: begin
                        cpu_clk <= 1'b0;
                        if (trigger) begin
                            state      <= HIGH;
                            cpu_clk    <= 1'b1;
                            step_pulse <= 1'b1;
                            ph_cnt     <= '0;
                            step_count <= step_count + 1'b1;
                        end
                    end
                    HIGH: begin
                        if (ph_cnt == PH_LAST) begin
                            state   <= LOW;
                            cpu_clk <= 1'b0;
                            ph_cnt  <= '0;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    LOW: begin
                        if (ph_cnt == PH_LAST) begin
                            state  <= IDLE;
                            ph_cnt <= '0;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cpu_clk <= 1'b0;
                        ph_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    // The synced step and reset levels feed the debouncers through sync2;
    // these aliases keep the bit mapping readable at the use sites.
    logic unused_ok;
    assign unused_ok = step_sync ^ rst_sync;

endmodule

// File: tb/tb_step_controller.sv
// ----------------------------------------------------------------------------
// tb_step_controller
//
// Directed bench for step_controller with small parameters
// (DEBOUNCE_CYCLES=8, PULSE_HIGH=4, RUN_DIV=20). Expected step_count values
// are queued when a step is requested and compared by a monitor at every
// step_pulse; directed checks cover timing boundaries and reset behaviour.
// ----------------------------------------------------------------------------
module tb_step_controller;

    localparam int DB = 8;
    localparam int PH = 4;
    localparam int RD = 20;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        key_step_n = 1'b1;
    logic        key_rst_n  = 1'b1;
    logic        run_mode   = 1'b0;
    logic        cpu_clk;
    logic        step_pulse;
    logic        cpu_reset;
    logic [15:0] step_count;

    int          checks = 0;
    int          errors = 0;

    logic [15:0] exp_q [$];
    bit          sb_mode        = 1'b1;
    bit          track_interval = 1'b0;
    bit          have_last      = 1'b0;
    int          cyc            = 0;
    int          last_pulse_cyc = 0;
    int          pulse_total    = 0;
    logic        prev_cpu_clk   = 1'b0;

    always #5 clk = ~clk;

    step_controller #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_HIGH     (PH),
        .RUN_DIV        (RD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_step_n(key_step_n),
        .key_rst_n (key_rst_n),
        .run_mode  (run_mode),
        .cpu_clk   (cpu_clk),
        .step_pulse(step_pulse),
        .cpu_reset (cpu_reset),
        .step_count(step_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: every step_pulse must coincide with a cpu_clk rise
    // and, when scoreboarding, carry the next queued step_count.
    always @(negedge clk) begin
        cyc++;
        if (step_pulse === 1'b1) begin
            pulse_total++;
            check("pulse_on_rise", {30'd0, prev_cpu_clk, cpu_clk}, 32'd1);
            if (sb_mode) begin
                if (exp_q.size() == 0) begin
                    check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                end else begin
                    check("step_count_sb", {16'd0, step_count}, {16'd0, exp_q.pop_front()});
                end
            end
            if (track_interval) begin
                if (have_last) begin
                    check("auto_interval", cyc - last_pulse_cyc, RD);
                end
                have_last = 1'b1;
            end
            last_pulse_cyc = cyc;
        end
        prev_cpu_clk = cpu_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_auto;

        // Reset state.
        #12;
        check("rst_cpu_clk",    cpu_clk,    1'b0);
        check("rst_step_pulse", step_pulse, 1'b0);
        check("rst_cpu_reset",  cpu_reset,  1'b0);
        check("rst_step_count", step_count, 16'd0);
        @(negedge clk);
        reset = 1'b1;

        // Idle: nothing happens with keys released.
        tick(100);
        check("idle_cpu_clk",    cpu_clk,     1'b0);
        check("idle_step_count", step_count,  16'd0);
        check("idle_cpu_reset",  cpu_reset,   1'b0);
        check("idle_no_pulse",   pulse_total, 0);

        // Manual step: key held for 50 cycles gives exactly one step.
        exp_q.push_back(16'd1);
        key_step_n = 1'b0;
        tick(10);
        check("pulse_not_early", step_pulse, 1'b0);
        tick(1);
        check("pulse_at_11",     step_pulse, 1'b1);
        check("high_first",      cpu_clk,    1'b1);
        tick(3);
        check("high_last",       cpu_clk,    1'b1);
        tick(1);
        check("low_first",       cpu_clk,    1'b0);
        tick(3);
        check("low_min",         cpu_clk,    1'b0);
        tick(32);
        key_step_n = 1'b1;
        tick(30);
        check("held_single_count", step_count,  16'd1);
        check("held_single_pulse", pulse_total, 1);

        // Bounce shorter than the debounce window is ignored.
        key_step_n = 1'b0;
        tick(5);
        key_step_n = 1'b1;
        tick(30);
        check("bounce_count", step_count,  16'd1);
        check("bounce_pulse", pulse_total, 1);

        // Auto-run for 200 cycles with a key press that must be ignored.
        for (int k = 2; k <= 11; k++) exp_q.push_back(16'(k));
        have_last      = 1'b0;
        track_interval = 1'b1;
        run_mode       = 1'b1;
        tick(50);
        key_step_n = 1'b0;
        tick(40);
        key_step_n = 1'b1;
        tick(110);
        run_mode = 1'b0;
        tick(30);
        track_interval = 1'b0;
        n_auto = 10 - exp_q.size();
        check("auto_pulse_count", 32'(n_auto >= 9 && n_auto <= 10), 32'd1);
        check("auto_count_final", {16'd0, step_count}, 32'(1 + n_auto));
        exp_q.delete();

        // Processor reset key pressed during auto-run.
        sb_mode  = 1'b0;
        run_mode = 1'b1;
        tick(30);
        key_rst_n = 1'b0;
        tick(10);
        check("cpu_rst_not_early", cpu_reset, 1'b0);
        tick(1);
        check("cpu_rst_at_11",     cpu_reset,  1'b1);
        check("cpu_rst_clk_low",   cpu_clk,    1'b0);
        check("cpu_rst_count",     step_count, 16'd0);
        tick(4);
        check("cpu_rst_hold_pulse", step_pulse, 1'b0);
        check("cpu_rst_hold_clk",   cpu_clk,    1'b0);
        check("cpu_rst_hold_count", step_count, 16'd0);
        tick(5);
        exp_q.push_back(16'd1);
        sb_mode   = 1'b1;
        key_rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) break;
        end
        check("resume_pulse", step_pulse, 1'b1);
        check("resume_cpu_reset", cpu_reset, 1'b0);
        run_mode = 1'b0;
        tick(40);
        check("resume_queue_empty", exp_q.size(), 0);
        check("resume_count", step_count, 16'd1);

        // Counter wrap from 0xFFFF.
        force dut.step_count = 16'hFFFF;
        @(negedge clk);
        release dut.step_count;
        tick(1);
        check("preload", step_count, 16'hFFFF);
        exp_q.push_back(16'h0000);
        key_step_n = 1'b0;
        tick(20);
        key_step_n = 1'b1;
        tick(20);
        check("wrap", step_count, 16'h0000);
        check("wrap_queue_empty", exp_q.size(), 0);

        // Block reset asserted in the middle of a HIGH phase.
        exp_q.push_back(16'h0001);
        key_step_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cpu_clk === 1'b1) break;
        end
        check("mid_high_reached", cpu_clk, 1'b1);
        tick(2);
        check("pre_reset_high", cpu_clk, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("async_clk_drop",  cpu_clk,    1'b0);
        check("async_count_clr", step_count, 16'd0);
        check("async_pulse_clr", step_pulse, 1'b0);
        check("async_cpu_rst",   cpu_reset,  1'b0);
        key_step_n = 1'b1;
        check("final_queue_empty", exp_q.size(), 0);
        tick(3);
        reset = 1'b1;
        tick(20);
        check("post_reset_clk",   cpu_clk,    1'b0);
        check("post_reset_count", step_count, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
